// File: rtl/add_pipe.sv
// rtl/add_pipe.sv - skewed-pipeline ripple adder/subtractor with valid/ready handshake
module add_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int SLICE = WIDTH / STAGES;

    logic en;

    // Stage inputs: operand remainders, partial sums and ripple carry as seen by stage k
    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic             c_d [STAGES];
    logic             v_d [STAGES];

    logic [SLICE:0]   sl  [STAGES];
    logic [WIDTH-1:0] s_n [STAGES];
    logic             c_n [STAGES];
    logic             ovf_n;

    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];

    logic [WIDTH-1:0] s_r;
    logic             cout_r;
    logic             ovf_r;
    logic             unused_tail;

    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign out_valid = v_q[STAGES-1];
    assign s         = s_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

    // Subtraction is folded in at entry, so later stages only ever add
    always_comb begin
        a_d[0] = a;
        b_d[0] = b ^ {WIDTH{sub}};
        c_d[0] = cin ^ sub;
        s_d[0] = '0;
        v_d[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_d[k] = a_q[k-1];
            b_d[k] = b_q[k-1];
            c_d[k] = c_q[k-1];
            s_d[k] = s_q[k-1];
            v_d[k] = v_q[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            sl[k]  = {1'b0, a_d[k][k*SLICE +: SLICE]} + {1'b0, b_d[k][k*SLICE +: SLICE]}
                   + (SLICE+1)'(c_d[k]);
            s_n[k] = s_d[k];
            s_n[k][k*SLICE +: SLICE] = sl[k][SLICE-1:0];
            c_n[k] = sl[k][SLICE];
        end
        // Same-sign operands giving an opposite-sign sum == carry-in/carry-out disagreement at the MSB
        ovf_n = (a_d[STAGES-1][WIDTH-1] ~^ b_d[STAGES-1][WIDTH-1])
              & (a_d[STAGES-1][WIDTH-1] ^ s_n[STAGES-1][WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) v_q[k] <= 1'b0;
            s_r    <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) v_q[k] <= v_d[k];
            s_r    <= s_n[STAGES-1];
            cout_r <= c_n[STAGES-1];
            ovf_r  <= ovf_n;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_n[k];
                c_q[k] <= c_n[k];
            end
        end
    end

    // The last stage's data copies are superseded by the reset-able output registers
    assign unused_tail = ^{a_q[STAGES-1], b_q[STAGES-1], s_q[STAGES-1], c_q[STAGES-1]};
endmodule

// File: tb/tb_add_pipe.sv
// tb/tb_add_pipe.sv - directed-vector bench for add_pipe (WIDTH=16, STAGES=4)
module tb_add_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a, b, s;
    logic        cin, sub, in_valid, in_ready, cout, ovf, out_valid, out_ready;

    int n_vec  = 0;
    int n_miss = 0;

    add_pipe #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .sub(sub),
        .in_valid(in_valid), .in_ready(in_ready), .s(s), .cout(cout), .ovf(ovf),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        ci;
        logic        sb;
        logic [17:0] exp;   // {cout, ovf, s}
    } vec_t;

    vec_t dir_vecs[$] = '{
        '{16'h0000, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0001}},
        '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, {1'b1, 1'b0, 16'hFFFF}},
        '{16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000}},
        '{16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE}},
        '{16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF}},
        '{16'h1234, 16'h4321, 1'b0, 1'b0, {1'b0, 1'b0, 16'h5555}},
        '{16'h0010, 16'h0001, 1'b1, 1'b1, {1'b1, 1'b0, 16'h000E}},
        '{16'h00FF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0100}},
        '{16'h0FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h1000}},
        '{16'h8000, 16'h8000, 1'b0, 1'b0, {1'b1, 1'b1, 16'h0000}}
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: full-width sum, overflow from carry into vs. out of the MSB
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic sb);
        logic [15:0] yx;
        logic        cx;
        logic [16:0] full;
        logic [15:0] low;
        yx   = y ^ {16{sb}};
        cx   = ci ^ sb;
        full = {1'b0, x} + {1'b0, yx} + 17'(cx);
        low  = {1'b0, x[14:0]} + {1'b0, yx[14:0]} + 16'(cx);
        return {full[16], full[16] ^ low[15], full[15:0]};
    endfunction

    task automatic run_one(input logic [15:0] x, input logic [15:0] y,
                           input logic ci, input logic sb, input logic [17:0] exp);
        int lat;
        @(negedge clk);
        a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'd4);
        check("result", 32'({cout, ovf, s}), 32'(exp));
        @(posedge clk); #1;
        check("drain", 32'(out_valid), 32'd0);
    endtask

    task automatic run_stream(input int n, input bit rnd_ready, input bit gaps);
        logic [17:0] q[$];
        logic [17:0] prev_out, expv;
        logic        prev_stall, acc, emit;
        int          sent, got, cyc, first_c, last_c;
        sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; prev_out = '0;
        first_c = -1; last_c = -1;
        while ((sent < n || got < n) && cyc < 2000) begin
            @(negedge clk);
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sent < n && (!gaps || $urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1;
                a   = 16'($urandom);
                b   = 16'($urandom);
                cin = 1'($urandom_range(0, 1));
                sub = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (prev_stall)
                check("stall_hold", 32'({out_valid, cout, ovf, s}), 32'({1'b1, prev_out}));
            check("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            acc  = in_valid && in_ready;
            emit = out_valid && out_ready;
            if (emit) begin
                if (q.size() == 0) begin
                    check("spurious_out", 32'(q.size()), 32'd1);
                end else begin
                    expv = q.pop_front();
                    check("stream_result", 32'({cout, ovf, s}), 32'(expv));
                end
                got++;
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
            end
            if (acc) begin
                q.push_back(model(a, b, cin, sub));
                sent++;
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {cout, ovf, s};
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_sent", 32'(sent), 32'(n));
        check("stream_got", 32'(got), 32'(n));
        if (!rnd_ready && !gaps)
            check("back_to_back", 32'(last_c - first_c), 32'(n - 1));
    endtask

    initial begin
        int stale;
        rst_n = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        #12;
        check("reset_outputs", 32'({out_valid, cout, ovf, s}), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (dir_vecs[i])
            run_one(dir_vecs[i].x, dir_vecs[i].y, dir_vecs[i].ci, dir_vecs[i].sb, dir_vecs[i].exp);

        run_stream(8, 1'b0, 1'b0);
        run_stream(40, 1'b1, 1'b1);

        // Three operands in flight, first result parked at the output behind out_ready=0
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 16'h1111 * 16'(i + 1); b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_reset_out", 32'({out_valid, cout, ovf, s}), 32'({1'b1, 1'b0, 1'b0, 16'h3333}));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_out", 32'({out_valid, cout, ovf, s}), 32'd0);
        check("async_reset_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("no_stale_valid", 32'(stale), 32'd0);
        run_one(16'h0123, 16'h0456, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0579});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
